hilo_muldiv: RTL and testbench

Iterative multiply/divide unit with its own HI/LO result registers. It sits in the execute stage, directly downstream of the register-file read ports, and consumes the rs/rt operand pair for MULT/MULTU/DIV/DIVU. It computes a 64-bit product or a quotient/remainder pair in 33 cycles. Results stay in HI/LO for later MFHI/MFLO. The pipeline stalls on `busy_o`.

---
 rtl/hilo_muldiv_pkg.sv | 21 ++
 rtl/hilo_muldiv_if.sv | 28 ++
 rtl/hilo_muldiv_sign_fix.sv | 41 ++++
 rtl/hilo_muldiv.sv | 166 ++++++++++++++++
 tb/tb_hilo_muldiv.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM states, iteration count and the divide-by-zero quotient.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int MD_ITERS = 32;

  // LO value written when the divisor is zero
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/hilo_muldiv_if.sv
// Execute-stage connection to the multiply/divide unit.
// Handshake: start_i is a request sampled only while busy_o is low; once
// accepted, busy_o stays high until HI/LO are written, and done_o pulses for
// exactly one cycle afterwards. mthi_i/mtlo_i follow the same rule and are
// dropped whenever start_i is accepted in the same cycle or busy_o is high.
interface hilo_muldiv_if;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs_i;
  logic [31:0] rt_i;
  logic        mthi_i;
  logic        mtlo_i;
  logic [31:0] mtdata_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport slave (
    input  start_i, op_i, rs_i, rt_i, mthi_i, mtlo_i, mtdata_i,
    output busy_o, done_o, hi_o, lo_o
  );

  modport master (
    output start_i, op_i, rs_i, rt_i, mthi_i, mtlo_i, mtdata_i,
    input  busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_muldiv_sign_fix.sv
// Final sign correction: turns the magnitude product or quotient/remainder
// into the architectural HI/LO values, including the divide-by-zero result.
import muldiv_pkg::*;

module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]         op_i,
  input  logic               sign_a_i,
  input  logic               sign_b_i,
  input  logic               div0_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   rem_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  logic               is_signed;
  logic               neg_res;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Negate by operand signs; remainder follows the dividend sign
  always_comb begin
    is_signed = ~op_i[0];
    neg_res   = is_signed & (sign_a_i ^ sign_b_i);
    prod_fix  = neg_res ? (~acc_i + 1'b1) : acc_i;
    quot_fix  = neg_res ? (~acc_i[WIDTH-1:0] + 1'b1) : acc_i[WIDTH-1:0];
    rem_fix   = (is_signed & sign_a_i) ? (~rem_i + 1'b1) : rem_i;
    hi_o      = prod_fix[2*WIDTH-1:WIDTH];
    lo_o      = prod_fix[WIDTH-1:0];
    if (op_i[1]) begin
      // Zero divisor leaves the dividend magnitude in the remainder, so the
      // remainder fix already restores the original rs; only LO is forced.
      hi_o = rem_fix;
      lo_o = div0_i ? DIV0_QUOT : quot_fix;
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative 32-cycle multiply / restoring divide with HI/LO result
// registers. Arithmetic runs on operand magnitudes; signs are applied in FIX.
import muldiv_pkg::*;

module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  hilo_muldiv_if.slave    bus,
  output state_t          dbg_state_o
);

  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       load, iterate, commit, mt_en;

  logic [1:0]         op_q;
  logic               sign_a_q, sign_b_q, div0_q;
  logic [WIDTH-1:0]   opnd_q;   // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q;    // product accumulator, or quotient in low half
  logic [WIDTH-1:0]   rem_q;    // restored partial remainder
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q;

  logic               in_signed, in_div, neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;  // 33-bit partial remainder after shift-in
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  // State and iteration counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and datapath control strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    iterate = 1'b0;
    commit  = 1'b0;
    mt_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          state_d = ST_CALC;
          cnt_d   = '0;
          load    = 1'b1;
        end else begin
          mt_en = 1'b1;
        end
      end
      ST_CALC: begin
        iterate = 1'b1;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'(MD_ITERS - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand decode and one shift-add / shift-subtract step
  always_comb begin
    in_signed = ~bus.op_i[0];
    in_div    = bus.op_i[1];
    neg_a     = in_signed & bus.rs_i[WIDTH-1];
    neg_b     = in_signed & bus.rt_i[WIDTH-1];
    mag_a     = neg_a ? (~bus.rs_i + 1'b1) : bus.rs_i;
    mag_b     = neg_b ? (~bus.rt_i + 1'b1) : bus.rt_i;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    // When div_ge holds the difference is below the divisor, so it fits WIDTH bits
    div_sub   = div_shift[WIDTH-1:0] - opnd_q;
  end

  // Operand latch and iteration registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      div0_q   <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
    end else if (load) begin
      op_q     <= bus.op_i;
      sign_a_q <= neg_a;
      sign_b_q <= neg_b;
      div0_q   <= in_div & (bus.rt_i == '0);
      opnd_q   <= in_div ? mag_b : mag_a;
      acc_q    <= {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
      rem_q    <= '0;
    end else if (iterate) begin
      if (op_q[1]) begin
        rem_q <= div_ge ? div_sub : div_shift[WIDTH-1:0];
        acc_q <= {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
      end else begin
        acc_q <= mul_next;
      end
    end
  end

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .op_i     (op_q),
    .sign_a_i (sign_a_q),
    .sign_b_i (sign_b_q),
    .div0_i   (div0_q),
    .acc_i    (acc_q),
    .rem_i    (rem_q),
    .hi_o     (fix_hi),
    .lo_o     (fix_lo)
  );

  // HI/LO written by a completed operation or by MTHI/MTLO while idle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      hi_q <= fix_hi;
      lo_q <= fix_lo;
    end else if (mt_en) begin
      if (bus.mthi_i) hi_q <= bus.mtdata_i;
      if (bus.mtlo_i) lo_q <= bus.mtdata_i;
    end
  end

  // Registered busy and done status
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d != ST_IDLE);
      done_q <= commit;
    end
  end

  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: multiply/divide results, boundary divides,
// busy-time input masking, MTHI/MTLO, mid-operation reset and back-to-back.
import muldiv_pkg::*;

module tb_hilo_muldiv;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilo_muldiv_if bus();
  state_t dbg_state;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi, exp_lo;   // model of the architectural HI/LO

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start_i  = 1'b0;
    bus.op_i     = 2'b00;
    bus.rs_i     = '0;
    bus.rt_i     = '0;
    bus.mthi_i   = 1'b0;
    bus.mtlo_i   = 1'b0;
    bus.mtdata_i = '0;
  endtask

  // Present an operation and let edge E accept it
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op_i    = op;
    bus.rs_i    = a;
    bus.rt_i    = b;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
  endtask

  // Called just after edge E; returns just after edge E+33
  task automatic finish(input string tag, input logic inject,
                        input logic [31:0] hi_e, input logic [31:0] lo_e);
    int n = 0;
    int n_done = 0;
    logic held = 1'b1;
    while (bus.busy_o === 1'b1 && n < 40) begin
      n++;
      if (bus.done_o !== 1'b0) n_done++;
      if (bus.hi_o !== exp_hi || bus.lo_o !== exp_lo) held = 1'b0;
      if (inject && n == 8) begin
        bus.start_i  = 1'b1;
        bus.op_i     = OP_DIVU;
        bus.rs_i     = 32'd1;
        bus.rt_i     = 32'd1;
        bus.mthi_i   = 1'b1;
        bus.mtdata_i = 32'hAAAA_5555;
      end
      tick();
      bus.start_i = 1'b0;
      bus.mthi_i  = 1'b0;
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'd33);
    check({tag, "_done_early"}, 32'(n_done), 32'd0);
    check({tag, "_hilo_held"}, {31'b0, held}, 32'd1);
    check({tag, "_done"}, {31'b0, bus.done_o}, 32'd1);
    check({tag, "_hi"}, bus.hi_o, hi_e);
    check({tag, "_lo"}, bus.lo_o, lo_e);
    exp_hi = hi_e;
    exp_lo = lo_e;
  endtask

  initial begin
    idle_inputs();
    exp_hi = '0;
    exp_lo = '0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", {31'b0, bus.busy_o}, 32'd0);
    check("rst_done", {31'b0, bus.done_o}, 32'd0);
    check("rst_hi", bus.hi_o, 32'd0);
    check("rst_lo", bus.lo_o, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    tick();

    // signed multiply: -2 * 3 = -6
    launch(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    finish("mult_neg", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    tick();
    check("mult_done_clr", {31'b0, bus.done_o}, 32'd0);

    // unsigned multiply of the largest operands
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish("multu_max", 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);

    // signed divide: -7 / 2 = -3 rem -1
    launch(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    finish("div_neg", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    launch(OP_DIVU, 32'd7, 32'd2);
    finish("divu_7_2", 1'b0, 32'd1, 32'd3);

    // divide by zero keeps original rs in HI
    launch(OP_DIV, 32'h0000_1234, 32'h0);
    finish("div_zero_pos", 1'b0, 32'h0000_1234, 32'hFFFF_FFFF);
    launch(OP_DIV, 32'hFFFF_FFF0, 32'h0);
    finish("div_zero_neg", 1'b0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    finish("div_ovf", 1'b0, 32'h0, 32'h8000_0000);
    tick();

    // MTLO in idle, then both MTHI and MTLO together
    bus.mtlo_i   = 1'b1;
    bus.mtdata_i = 32'hDEAD_BEEF;
    tick();
    bus.mtlo_i = 1'b0;
    check("mtlo_lo", bus.lo_o, 32'hDEAD_BEEF);
    check("mtlo_hi_keep", bus.hi_o, exp_hi);
    exp_lo = 32'hDEAD_BEEF;

    bus.mthi_i   = 1'b1;
    bus.mtlo_i   = 1'b1;
    bus.mtdata_i = 32'h0BAD_F00D;
    tick();
    bus.mthi_i = 1'b0;
    bus.mtlo_i = 1'b0;
    check("mtboth_hi", bus.hi_o, 32'h0BAD_F00D);
    check("mtboth_lo", bus.lo_o, 32'h0BAD_F00D);
    exp_hi = 32'h0BAD_F00D;
    exp_lo = 32'h0BAD_F00D;

    // start wins over a simultaneous MTHI
    bus.mthi_i   = 1'b1;
    bus.mtdata_i = 32'h1234_5678;
    launch(OP_MULTU, 32'd3, 32'd4);
    bus.mthi_i = 1'b0;
    check("start_mthi_busy", {31'b0, bus.busy_o}, 32'd1);
    check("start_mthi_hi", bus.hi_o, exp_hi);
    finish("start_mthi", 1'b0, 32'd0, 32'd12);

    // start and MTHI pulsed mid-CALC are ignored
    launch(OP_MULTU, 32'd5, 32'd6);
    finish("busy_inject", 1'b1, 32'd0, 32'd30);
    tick();
    check("busy_inject_idle", {31'b0, bus.busy_o}, 32'd0);

    // asynchronous reset around iteration 10 of a divide
    launch(OP_DIV, 32'd100, 32'd7);
    for (int i = 0; i < 10; i++) tick();
    check("pre_rst_busy", {31'b0, bus.busy_o}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'b0, bus.busy_o}, 32'd0);
    check("midrst_done", {31'b0, bus.done_o}, 32'd0);
    check("midrst_hi", bus.hi_o, 32'd0);
    check("midrst_lo", bus.lo_o, 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_hi = '0;
    exp_lo = '0;
    tick();
    rst = 1'b0;
    tick();

    launch(OP_MULT, 32'd2, 32'd3);
    finish("post_rst_mult", 1'b0, 32'd0, 32'd6);

    // back-to-back: start accepted at E+34 while done is high
    launch(OP_DIVU, 32'd100, 32'd7);
    check("b2b_busy", {31'b0, bus.busy_o}, 32'd1);
    check("b2b_done_clr", {31'b0, bus.done_o}, 32'd0);
    finish("b2b_divu", 1'b0, 32'd2, 32'd14);
    tick();
    check("final_done_clr", {31'b0, bus.done_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
